// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter and sequencer in front of a single-port RAM.
//
// M0 is the instruction-fetch port and M1 is the data load/store port.
// Accesses are serialised through a three-state sequence:
//   IDLE -> ACC -> RESP -> IDLE
// so at most one access completes every three cycles.
//
// Each requester holds req and its command until it sees a one-cycle ack.
// Read data is captured into a per-port register. That register keeps its
// value until the same port's next successful read.
// An address >= DEPTH is not sent to the RAM. Such an access still returns
// ack, with err set, and its timing matches a normal access.
//
// Optional feature (macro RAM_ARB_RR_EN):
//   defined   - round-robin on simultaneous requests. The port that did
//               not win the previous grant wins the tie.
//   undefined - fixed priority, M1 over M0.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   m0_req/wen/addr/wdata        M0 command inputs
//   m0_ack/err/rdata             M0 completion pulse, range error, read data
//   m1_*                         same set for M1
//   ram_cen/wen/addr/wdata       registered RAM command outputs
//   ram_rdata                    RAM read data, only meaningful during ACC
//   busy                         high whenever the sequencer is not IDLE
module ram_arbiter #(
  parameter int DW    = 16,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m0_req,
  input  logic          m0_wen,
  input  logic [DW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_wen,
  input  logic [DW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_cen,
  output logic          ram_wen,
  output logic [DW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  // One extra bit so DEPTH == 2**DW still compares correctly.
  localparam logic [DW:0] DEPTH_W = (DW+1)'(DEPTH);

  state_t state, next_state;

  logic          owner;      // 0 = M0, 1 = M1
  logic          lat_wen;
  logic          lat_err;
  logic          grant_m1;
  logic          sel_wen;
  logic [DW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_oor;

`ifdef RAM_ARB_RR_EN
  logic last_owner;
`endif

  // Winner selection, only acted on in IDLE.
  always_comb begin
    grant_m1 = m1_req;
`ifdef RAM_ARB_RR_EN
    if (m0_req && m1_req) grant_m1 = ~last_owner;
`endif
    sel_wen   = grant_m1 ? m1_wen   : m0_wen;
    sel_addr  = grant_m1 ? m1_addr  : m0_addr;
    sel_wdata = grant_m1 ? m1_wdata : m0_wdata;
    sel_oor   = ({1'b0, sel_addr} >= DEPTH_W);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (m0_req || m1_req) next_state = ACC;
      ACC:     next_state = RESP;
      RESP:    next_state = IDLE;   // reqs are deliberately not sampled here
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner     <= 1'b0;
      lat_wen   <= 1'b0;
      lat_err   <= 1'b0;
      ram_cen   <= 1'b0;
      ram_wen   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      m0_ack    <= 1'b0;
      m0_err    <= 1'b0;
      m1_ack    <= 1'b0;
      m1_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      // Strobes default low so each lasts exactly one cycle.
      m0_ack  <= 1'b0;
      m0_err  <= 1'b0;
      m1_ack  <= 1'b0;
      m1_err  <= 1'b0;
      ram_cen <= 1'b0;
      ram_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner     <= grant_m1;
            lat_wen   <= sel_wen;
            lat_err   <= sel_oor;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
            // An out-of-range access never enables the RAM.
            ram_cen   <= ~sel_oor;
            ram_wen   <= sel_wen & ~sel_oor;
          end
        end
        ACC: begin
          // ram_rdata is only driven during ACC, so it is captured at the
          // edge that closes ACC.
          if (!lat_wen && !lat_err) begin
            if (owner) m1_rdata <= ram_rdata;
            else       m0_rdata <= ram_rdata;
          end
          if (owner) begin
            m1_ack <= 1'b1;
            m1_err <= lat_err;
          end else begin
            m0_ack <= 1'b1;
            m0_err <= lat_err;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RAM_ARB_RR_EN
  // After reset this points at M1, so M0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             last_owner <= 1'b1;
    else if (state == IDLE && (m0_req || m1_req)) last_owner <= grant_m1;
  end
`endif

endmodule
